// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg
//   Shared constants for the M-extension multiply/divide unit: the RV32M
//   funct3 encodings (also used by the decoder and hazard unit), the FSM
//   state encoding, and a helper to classify an op as multiply or divide.
package muldiv_unit_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    // funct3[2] splits the M-extension into multiplies and divides.
    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix
//   Combinational sign handling around the unsigned iteration datapath.
//   Front half: per-op magnitude extraction of the raw operands plus the
//   sign / divide-by-zero / overflow flags that get latched at accept.
//   Back half: applies the latched sign to the final accumulator, selects
//   the op's result and applies the divide-by-zero and overflow overrides.
// Ports:
//   op_in, opa, opb     raw op and operands presented at accept
//   mag_a, mag_b        unsigned magnitudes of opa / opb
//   neg_res, neg_rem    product/quotient negate flag, remainder negate flag
//   div_zero, overflow  divisor==0, signed most-negative / -1 case
//   op_q, opa_q, *_q    the latched versions of the above
//   acc                 final 2*XLEN accumulator ({hi,lo} or {rem,quo})
//   result              final XLEN-bit result
module muldiv_sign_fix
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        op_in,
    input  logic [XLEN-1:0]   opa,
    input  logic [XLEN-1:0]   opb,
    output logic [XLEN-1:0]   mag_a,
    output logic [XLEN-1:0]   mag_b,
    output logic              neg_res,
    output logic              neg_rem,
    output logic              div_zero,
    output logic              overflow,
    input  logic [2:0]        op_q,
    input  logic [XLEN-1:0]   opa_q,
    input  logic              neg_res_q,
    input  logic              neg_rem_q,
    input  logic              div_zero_q,
    input  logic              overflow_q,
    input  logic [2*XLEN-1:0] acc,
    output logic [XLEN-1:0]   result
);

    logic              a_signed;
    logic              b_signed;
    logic              sa;
    logic              sb;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;

    // MUL only uses the low half, which is identical for signed and
    // unsigned operands, so it is treated as unsigned.
    always_comb begin
        a_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                   (op_in == OP_DIV)  || (op_in == OP_REM);
        b_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
        sa       = a_signed & opa[XLEN-1];
        sb       = b_signed & opb[XLEN-1];
        // The most-negative value negates to itself, which read as unsigned
        // is exactly its magnitude.
        mag_a    = sa ? -opa : opa;
        mag_b    = sb ? -opb : opb;
        neg_res  = sa ^ sb;
        neg_rem  = sa;
        div_zero = (opb == '0);
        overflow = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                   (opa == {1'b1, {(XLEN-1){1'b0}}}) && (opb == '1);
    end

    always_comb begin
        prod = neg_res_q ? -acc : acc;
        quo  = neg_res_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg_rem_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                       result = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result = div_zero_q ? '1 :
                                                   overflow_q ? opa_q : quo;
            default:                      result = div_zero_q ? opa_q :
                                                   overflow_q ? '0 : rem;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative RV32M multiply/divide unit; every op takes XLEN iterations.
//   Multiply is shift-add on magnitudes; divide is restoring on magnitudes.
// Ports:
//   CPU_CLK, CPU_RST_N  clock, synchronous active-low reset
//   Start               request, accepted only in IDLE (and not with Flush)
//   Flush               aborts any operation, no Done pulse
//   MulDivOp            RV32M funct3
//   Operand1, Operand2  rs1 / rs2 values, sampled only at accept
//   Busy                high in CALC and DONE
//   Done                one-cycle pulse, Result valid from this cycle on
//   Result              registered result, held until the next Done
//
// Handshake: Start is taken on an edge where state is IDLE and Flush is low;
// Busy then stays high until the edge after Done, and any Start seen while
// Busy is dropped. Done is high exactly XLEN cycles after the accept edge.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CPU_CLK,
    input  logic            CPU_RST_N,
    input  logic            Start,
    input  logic            Flush,
    input  logic [2:0]      MulDivOp,
    input  logic [XLEN-1:0] Operand1,
    input  logic [XLEN-1:0] Operand2,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    muldiv_state_t     state;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   opa_q;
    logic [XLEN-1:0]   addend;
    logic [2*XLEN-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic              neg_res_q;
    logic              neg_rem_q;
    logic              div_zero_q;
    logic              overflow_q;
    logic [XLEN-1:0]   result_q;

    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              neg_res;
    logic              neg_rem;
    logic              div_zero;
    logic              overflow;
    logic [XLEN-1:0]   fix_result;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN:0]   mul_shift;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] acc_nxt;
    logic [CNT_W-1:0]  cnt_nxt;

    // Result is formed from acc_nxt so the last iteration and the result
    // write share the same edge that enters DONE.
    muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .op_in      (MulDivOp),
        .opa        (Operand1),
        .opb        (Operand2),
        .mag_a      (mag_a),
        .mag_b      (mag_b),
        .neg_res    (neg_res),
        .neg_rem    (neg_rem),
        .div_zero   (div_zero),
        .overflow   (overflow),
        .op_q       (op_q),
        .opa_q      (opa_q),
        .neg_res_q  (neg_res_q),
        .neg_rem_q  (neg_rem_q),
        .div_zero_q (div_zero_q),
        .overflow_q (overflow_q),
        .acc        (acc_nxt),
        .result     (fix_result)
    );

    // acc is {hi, lo} for multiply (lo starts as the multiplier and is
    // consumed LSB first) and {rem, quo} for divide (quo starts as the
    // dividend and is consumed MSB first while quotient bits shift in).
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, addend} : '0);
        mul_shift = {mul_sum, acc[XLEN-1:0]};
        // rem < divisor holds, so the shifted remainder minus the divisor is
        // below 2^XLEN when non-negative; bit XLEN therefore flags a borrow.
        div_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, addend};
        if (op_is_div(op_q)) begin
            if (!div_trial[XLEN]) begin
                acc_nxt = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt = {acc[2*XLEN-2:0], 1'b0};
            end
        end else begin
            acc_nxt = mul_shift[2*XLEN:1];
        end
        cnt_nxt = cnt + CNT_W'(1);
    end

    always_ff @(posedge CPU_CLK) begin
        if (!CPU_RST_N) begin
            state      <= IDLE;
            op_q       <= '0;
            opa_q      <= '0;
            addend     <= '0;
            acc        <= '0;
            cnt        <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
            result_q   <= '0;
        end else if (Flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        op_q       <= MulDivOp;
                        opa_q      <= Operand1;
                        addend     <= op_is_div(MulDivOp) ? mag_b : mag_a;
                        acc        <= {{XLEN{1'b0}}, (op_is_div(MulDivOp) ? mag_a : mag_b)};
                        cnt        <= '0;
                        neg_res_q  <= neg_res;
                        neg_rem_q  <= neg_rem;
                        div_zero_q <= div_zero;
                        overflow_q <= overflow;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt_nxt;
                    if (cnt_nxt == CNT_W'(XLEN)) begin
                        result_q <= fix_result;
                        state    <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy   = (state == CALC) || (state == DONE);
    assign Done   = (state == DONE);
    assign Result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
//   Directed vectors for muldiv_unit at XLEN=32 plus one MUL at XLEN=16.
//   Expected results and Done cycles are queued when an op is issued; a
//   monitor pops and compares whenever Done is seen.
module tb_muldiv_unit;

    localparam int W   = 32;
    localparam int W16 = 16;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic           start, flush;
    logic [2:0]     op_s;
    logic [W-1:0]   op1, op2;
    logic           busy, done;
    logic [W-1:0]   result;

    logic           start16;
    logic [2:0]     op16;
    logic [W16-1:0] a16, b16;
    logic           busy16, done16;
    logic [W16-1:0] result16;

    muldiv_unit #(.XLEN(W)) dut (
        .CPU_CLK   (clk),
        .CPU_RST_N (rst_n),
        .Start     (start),
        .Flush     (flush),
        .MulDivOp  (op_s),
        .Operand1  (op1),
        .Operand2  (op2),
        .Busy      (busy),
        .Done      (done),
        .Result    (result)
    );

    muldiv_unit #(.XLEN(W16)) dut16 (
        .CPU_CLK   (clk),
        .CPU_RST_N (rst_n),
        .Start     (start16),
        .Flush     (1'b0),
        .MulDivOp  (op16),
        .Operand1  (a16),
        .Operand2  (b16),
        .Busy      (busy16),
        .Done      (done16),
        .Result    (result16)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    logic [W-1:0] exp16_q[$];
    int           exp16_cyc_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] last_exp = '0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [W-1:0] mon_e;
    int           mon_c;
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done32: Done=1 with no pending op, Result=%h (cycle %0d)", result, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = exp_cyc_q.pop_front();
                check("result32", result, mon_e);
                check("latency32", cyc, mon_c);
            end
        end
    end

    logic [W-1:0] mon16_e;
    int           mon16_c;
    always @(negedge clk) begin
        if (done16) begin
            if (exp16_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done16: Done=1 with no pending op, Result=%h (cycle %0d)", result16, cyc);
            end else begin
                mon16_e = exp16_q.pop_front();
                mon16_c = exp16_cyc_q.pop_front();
                check("result16", {{(W-W16){1'b0}}, result16}, mon16_e);
                check("latency16", cyc, mon16_c);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Issues one op, checks Busy through CALC and DONE and its drop after.
    // poke>0 pulses a competing Start during CALC, which must be ignored.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] expv, input int poke);
        @(negedge clk);
        start = 1'b1;
        op_s  = op;
        op1   = a;
        op2   = b;
        exp_q.push_back(expv);
        exp_cyc_q.push_back(cyc + 1 + W);
        last_exp = expv;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            start = (poke != 0) && (i == poke);
            op_s  = 3'($urandom_range(0, 7));
            op1   = $urandom;
            op2   = $urandom;
            check("busy_calc", {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        start = 1'b0;
        check("busy_done", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op_s = '0; op1 = '0; op2 = '0;
        start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_result16", {16'd0, result16}, 32'd0);
        rst_n = 1'b1;

        run_op(MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0);
        run_op(MULH,   32'h80000000, 32'h80000000, 32'h40000000, 0);
        run_op(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
        run_op(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0);
        run_op(REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0);
        run_op(DIVU,   32'd100,      32'd7,        32'd14,       0);
        run_op(REMU,   32'd100,      32'd7,        32'd2,        0);
        run_op(DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 0);
        run_op(REMU,   32'd5,        32'd0,        32'd5,        0);
        run_op(DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
        run_op(REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        0);
        run_op(REM,    32'd7,        32'hFFFFFFFE, 32'd1,        0);
        run_op(DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 0);
        run_op(MULHU,  32'h12345678, 32'h00010000, 32'h00001234, 0);
        run_op(DIVU,   32'd100,      32'd7,        32'd14,       5);

        // Flush on edge T+10 of a DIV: idle next cycle, Result held, no Done.
        @(negedge clk);
        start = 1'b1; op_s = DIV; op1 = 32'd1000; op2 = 32'd3;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_result", result, last_exp);
        repeat (W + 4) @(negedge clk);
        check("flush_hold", result, last_exp);

        // Start with Flush in the same cycle is not accepted.
        start = 1'b1; flush = 1'b1; op_s = MUL; op1 = 32'd3; op2 = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("start_flush_busy", {31'd0, busy}, 32'd0);
        repeat (W + 4) @(negedge clk);

        // Reset in the middle of CALC discards the op.
        start = 1'b1; op_s = MUL; op1 = 32'd9; op2 = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        check("rst_mid_result", result, 32'd0);
        repeat (W + 4) @(negedge clk);

        // XLEN=16 instance.
        start16 = 1'b1; op16 = MUL; a16 = 16'h00FF; b16 = 16'h0101;
        exp16_q.push_back(32'h0000FFFF);
        exp16_cyc_q.push_back(cyc + 1 + W16);
        @(negedge clk);
        start16 = 1'b0; a16 = 16'hA5A5; b16 = 16'h5A5A;
        repeat (W16 + 4) @(negedge clk);

        check("pending32", exp_q.size(), 32'd0);
        check("pending16", exp16_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit, parametrised in operand width XLEN.
- Sits beside the single-cycle ALU in EX and handles all eight M-extension ops.
- Takes XLEN+1 cycles per operation. While it is busy, the hazard unit stalls IF/ID/EX using Busy.
- Results are signed- and unsigned-correct and include the RISC-V divide-by-zero and overflow rules.

Parameters:
- XLEN, 32, operand and result width; legal values 8..64, even.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; not overridden).

Ports:
- CPU_CLK  input  1  clock; all state updates on the rising edge.
- CPU_RST_N  input  1  synchronous, active-low reset, sampled on the CPU_CLK rising edge.
- Start  input  1  request; accepted only in IDLE.
- Flush  input  1  pipeline flush; aborts any operation in progress.
- MulDivOp  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Operand1  input  XLEN  rs1 value (multiplicand or dividend).
- Operand2  input  XLEN  rs2 value (multiplier or divisor).
- Busy  output  1  high in CALC and DONE.
- Done  output  1  one-cycle pulse; Result is valid from this cycle on.
- Result  output  XLEN  registered result, held until the next Done.

Behaviour:
- Reset (CPU_RST_N=0 at an edge):
  - state=IDLE; Busy=0, Done=0, Result=0.
  - All internal registers are cleared.
  - Reset mid-operation discards the operation; Done is not pulsed.
- States: IDLE, CALC, DONE. Busy and Done are decoded from state (Busy = CALC or DONE; Done = DONE).
- IDLE:
  - Start=1 and Flush=0 at edge T: latch MulDivOp, Operand1, Operand2 and the sign-conditioned magnitudes; clear counter; go to CALC.
  - Start=0: stay in IDLE.
- CALC:
  - One iteration per cycle. Multiply is shift-add on magnitudes with a 2*XLEN accumulator. Divide is restoring, on magnitudes, with an XLEN remainder and XLEN quotient.
  - After XLEN iterations (edges T+1..T+XLEN), go to DONE at T+XLEN.
- DONE:
  - Lasts exactly one cycle, T+XLEN..T+XLEN+1.
  - Result is written on the entering edge, so Done=1 and Result are valid in the same cycle.
  - Next state is IDLE.
- Start while Busy=1 is ignored (no queueing). A new Start is accepted in the first IDLE cycle after DONE.
- Flush=1 at any edge: next state IDLE, Result unchanged, no Done pulse. Flush beats a simultaneous Start.
- Fixed latency: Start accepted at edge T gives Done high during cycle T+XLEN. All ops take this latency, special cases included.
- Sign handling:
  - MULH: both operands signed.
  - MULHSU: Operand1 signed, Operand2 unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - DIV, REM: both operands signed.
  - The final product is negated when the operand signs differ (signed ops only).
  - The quotient is negated when the dividend and divisor signs differ.
  - The remainder takes the dividend's sign.
- Result selection: MUL = product[XLEN-1:0]; MULH/MULHSU/MULHU = product[2XLEN-1:XLEN].
- Divisor = 0 (flag latched at accept):
  - DIV/DIVU: Result = all ones.
  - REM/REMU: Result = Operand1.
- Signed overflow (Operand1 = most-negative, Operand2 = -1, DIV/REM only):
  - DIV: Result = Operand1.
  - REM: Result = 0.
- Width rules:
  - Counter wraps are impossible; it is compared against XLEN.
  - Magnitude of the most-negative value is held in XLEN bits as unsigned.
- Operand inputs may change after acceptance without effect.

Decomposition:
- Additions to shared Parameters.v:
  - MulDivOp encodings MUL..REMU, as 3-bit constants.
  - State encodings IDLE/CALC/DONE.
  - Shared by decoder, hazard unit and this block.
- One sub-module: muldiv_sign_fix, combinational. It has two jobs:
  - Input magnitude/sign extraction per op.
  - Output negation, plus the divide-by-zero and overflow override muxing.
- The iteration datapath and FSM stay in muldiv_unit.

Test Plan:
- XLEN=32, MUL 7 * -3 (Operand2=0xFFFFFFFD) -> Result 0xFFFFFFEB. Done high exactly 32 cycles after Start edge; Busy high for all 32 cycles.
- MULH 0x80000000 * 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5. Overflow: DIV 0x80000000/-1 -> 0x80000000; REM -> 0. Latency is still 32 cycles.
- Flush at cycle T+10 of a DIV -> IDLE next cycle, no Done pulse, Result keeps its previous value. Start+Flush in the same cycle -> not accepted.
- Start pulsed while Busy -> ignored, first Result unaffected. CPU_RST_N low mid-CALC -> Busy=0, Done=0, Result=0 next cycle. Repeat the MUL test at XLEN=16: 0x00FF * 0x0101 -> 0xFFFF, Done high 16 cycles after the Start edge.
